mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the LC-3 datapath. It answers the control unit's Mem_OE/Mem_WE strobes against the MAR address and MDR write data, and serves reads from an on-chip word array with a fixed, bounded latency. The latency matches the control unit's multi-cycle fetch/load wait states. Address IO_ADDR is memory-mapped I/O: reads return the board switches and writes load the hex-display register.

## Interface
- ADDR_W, 10, word-array address width; depth = 2^ADDR_W 16-bit words
- READ_LAT, 1, cycles from read-request capture to Data_valid; legal range 1..4
- IO_ADDR, 16'hFFFF, memory-mapped I/O address
- Clk  in  1  system clock, rising edge. One clock; reset is synchronous and active-high.
- Reset  in  1  synchronous, active-high
- Mem_OE  in  1  read strobe, active-high, held for whole access
- Mem_WE  in  1  write strobe, active-high, held for whole access
- ADDR  in  16  word address (from MAR)
- Data_from_CPU  in  16  write data (from MDR)
- Switches  in  16  board switches
- Data_to_CPU  out  16  registered read data (to MDR mux)
- Data_valid  out  1  Data_to_CPU holds the requested word
- HEX_out  out  16  hex-display register
- Err  out  1  sticky protocol/range error flag

## Operation
- States: IDLE, READ_WAIT, READ_HOLD, WRITE_HOLD.
- IDLE, Mem_WE=1:
  - Commit the write on this edge.
  - Go to WRITE_HOLD.
  - If Mem_OE=1 in the same cycle, Mem_WE wins, the read is ignored, and Err is set.
- IDLE, Mem_OE=1, Mem_WE=0:
  - Latch ADDR into an internal request register.
  - Load the wait counter with READ_LAT-1.
  - Go to READ_WAIT, or straight to READ_HOLD when READ_LAT=1.
- READ_WAIT:
  - Decrement the counter each cycle.
  - At 0, load Data_to_CPU, set Data_valid, and go to READ_HOLD.
  - Mem_OE sampled low: abort to IDLE. Data_valid stays 0 and the array is unaffected.
- READ_HOLD:
  - Data_to_CPU and Data_valid hold while Mem_OE=1.
  - Mem_OE sampled low: go to IDLE and clear Data_valid on that edge.
- WRITE_HOLD:
  - Wait for Mem_WE low, then go to IDLE.
  - Exactly one commit happens per WE assertion, however long WE is held.
- Address decode (uses the latched address for reads, live ADDR at the commit edge for writes):
  - Address == IO_ADDR: reads return Switches as registered one cycle earlier; writes load HEX_out.
  - Address < 2^ADDR_W: array word.
  - Otherwise out of range: reads return 16'h0000 and writes are dropped. Both set Err.
- ADDR and Data_from_CPU changes after capture are ignored until the next IDLE request.
- Err clears only on Reset.
- Reset:
  - Returns the FSM to IDLE from any state, aborting an in-flight access.
  - Data_to_CPU=0, Data_valid=0, HEX_out=0, Err=0, counter=0.
  - Array contents are not cleared.

## Timing
- Let edge n be the first rising edge at which Mem_OE=1 is sampled in IDLE.
- Data_valid=1 and Data_to_CPU are valid in the cycle following edge n+READ_LAT-1.
- With READ_LAT=1, data is valid in the cycle following edge n. Consequences for the control unit:
  - The second OE cycle (the LD_MDR cycle) sees valid data.
  - A three-cycle OE window is always sufficient.
- Write commit happens at edge n, where edge n is the first edge with Mem_WE=1 sampled in IDLE. A read of the same address starting on the next IDLE request returns the new value.
- At least one cycle in IDLE is required between accesses. A strobe held continuously across two accesses is one access.
- Data_valid falls on the edge at which Mem_OE is sampled low; there is no combinational path from Mem_OE to outputs.
- All outputs are registered.

## Test plan
- Reset, then write 16'h1234 to address 0x0005 (WE high 2 cycles), then OE 2 cycles at 0x0005 -> Data_valid=1 in 2nd OE cycle, Data_to_CPU=16'h1234.
- Write 16'hBEEF to 0xFFFF -> HEX_out=16'hBEEF after the commit edge; Switches=16'h00A5, read 0xFFFF -> Data_to_CPU=16'h00A5.
- READ_LAT=3, OE held 4 cycles -> Data_valid rises after exactly 3 edges; OE dropped after 1 cycle -> Data_valid never rises, FSM in IDLE.
- OE and WE together at 0x0010 with data 16'h0F0F -> word written, Data_valid stays 0, Err=1 until Reset.
- Read 0x2000 (out of range, ADDR_W=10) -> Data_to_CPU=0, Err=1; WE held 5 cycles -> single commit.
- Reset asserted in READ_WAIT -> next cycle state IDLE, Data_valid=0, HEX_out=0, array word 0x0005 still 16'h1234.

Source files
------------

// File: rtl/mem_responder_if.sv
// CPU-side memory bus between the LC-3 control unit and mem_responder.
// Board switch inputs travel with the bus so the responder has a single bus port.
interface mem_responder_if;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] ADDR;
    logic [15:0] Data_from_CPU;
    logic [15:0] Switches;
    logic [15:0] Data_to_CPU;
    logic        Data_valid;
    logic [15:0] HEX_out;
    logic        Err;

    modport master (
        output Mem_OE, Mem_WE, ADDR, Data_from_CPU, Switches,
        input  Data_to_CPU, Data_valid, HEX_out, Err
    );

    modport slave (
        input  Mem_OE, Mem_WE, ADDR, Data_from_CPU, Switches,
        output Data_to_CPU, Data_valid, HEX_out, Err
    );
endinterface

// File: rtl/mem_responder.sv
// LC-3 memory responder: word array plus memory-mapped switches/hex display,
// answering Mem_OE/Mem_WE strobes with a fixed read latency.
module mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          READ_LAT = 1,
    parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
    input  logic            Clk,
    input  logic            Reset,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        READ_HOLD,
        WRITE_HOLD
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t      r_state;
    state_t      w_next;

    logic [15:0] r_mem [0:DEPTH-1];
    logic [15:0] r_sw;
    logic [15:0] r_req_addr;
    logic [15:0] r_dout;
    logic [15:0] r_hex;
    logic        r_valid;
    logic        r_err;
    logic [1:0]  r_cnt;

    logic        w_wr;
    logic        w_conflict;
    logic        w_rd_start;
    logic        w_rd_load;
    logic        w_rd_clr;
    logic [15:0] w_rd_addr;
    logic        w_rd_io;
    logic        w_rd_in;
    logic [15:0] w_rd_data;
    logic        w_wr_io;
    logic        w_wr_in;

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_wr       = 1'b0;
        w_conflict = 1'b0;
        w_rd_start = 1'b0;
        w_rd_load  = 1'b0;
        w_rd_clr   = 1'b0;
        w_rd_addr  = r_req_addr;
        case (r_state)
            IDLE: begin
                if (bus.Mem_WE) begin
                    w_wr       = 1'b1;
                    w_conflict = bus.Mem_OE;
                    w_next     = WRITE_HOLD;
                end else if (bus.Mem_OE) begin
                    w_rd_start = 1'b1;
                    if (READ_LAT == 1) begin
                        // Single-cycle latency loads data on the capture edge
                        w_rd_load = 1'b1;
                        w_rd_addr = bus.ADDR;
                        w_next    = READ_HOLD;
                    end else begin
                        w_next = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (!bus.Mem_OE) begin
                    w_next = IDLE;
                end else if (r_cnt == 2'd1) begin
                    w_rd_load = 1'b1;
                    w_next    = READ_HOLD;
                end
            end
            READ_HOLD: begin
                if (!bus.Mem_OE) begin
                    w_rd_clr = 1'b1;
                    w_next   = IDLE;
                end
            end
            WRITE_HOLD: begin
                if (!bus.Mem_WE) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_rd_io   = (w_rd_addr == IO_ADDR);
    assign w_rd_in   = ((w_rd_addr >> ADDR_W) == 16'd0);
    assign w_wr_io   = (bus.ADDR == IO_ADDR);
    assign w_wr_in   = ((bus.ADDR >> ADDR_W) == 16'd0);
    assign w_rd_data = w_rd_io ? r_sw :
                       w_rd_in ? r_mem[w_rd_addr[ADDR_W-1:0]] : 16'h0000;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sw       <= 16'h0000;
            r_req_addr <= 16'h0000;
            r_dout     <= 16'h0000;
            r_hex      <= 16'h0000;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_sw <= bus.Switches;
            if (w_rd_start) begin
                r_req_addr <= bus.ADDR;
                r_cnt      <= 2'(READ_LAT - 1);
            end else if (r_state == READ_WAIT && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_rd_load) begin
                r_dout  <= w_rd_data;
                r_valid <= 1'b1;
                if (!w_rd_io && !w_rd_in) r_err <= 1'b1;
            end
            if (w_rd_clr) r_valid <= 1'b0;
            if (w_wr && w_wr_io) r_hex <= bus.Data_from_CPU;
            if (w_conflict || (w_wr && !w_wr_io && !w_wr_in)) r_err <= 1'b1;
        end
    end

    // Array contents survive reset; only the commit strobe is gated
    always_ff @(posedge Clk) begin
        if (!Reset && w_wr && w_wr_in && !w_wr_io)
            r_mem[bus.ADDR[ADDR_W-1:0]] <= bus.Data_from_CPU;
    end

    assign bus.Data_to_CPU = r_dout;
    assign bus.Data_valid  = r_valid;
    assign bus.HEX_out     = r_hex;
    assign bus.Err         = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with READ_LAT=1 and READ_LAT=3 instances.
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if if1();
    mem_responder_if if3();

    mem_responder #(.ADDR_W(10), .READ_LAT(1), .IO_ADDR(16'hFFFF)) u1 (
        .Clk(clk), .Reset(rst), .bus(if1)
    );
    mem_responder #(.ADDR_W(10), .READ_LAT(3), .IO_ADDR(16'hFFFF)) u3 (
        .Clk(clk), .Reset(rst), .bus(if3)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m1 [int];
    logic [15:0] m3 [int];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input logic [15:0] a, input logic [15:0] d,
                      input int cyc, input logic oe,
                      input logic [15:0] a2, input logic [15:0] d2);
        if (sel == 1) begin
            if1.ADDR = a; if1.Data_from_CPU = d; if1.Mem_WE = 1'b1; if1.Mem_OE = oe;
        end else begin
            if3.ADDR = a; if3.Data_from_CPU = d; if3.Mem_WE = 1'b1; if3.Mem_OE = oe;
        end
        if (a != 16'hFFFF && a < 16'h0400) begin
            if (sel == 1) m1[int'(a)] = d;
            else          m3[int'(a)] = d;
        end
        for (int i = 0; i < cyc; i++) begin
            step();
            if (i == 0) begin
                if (sel == 1) begin if1.ADDR = a2; if1.Data_from_CPU = d2; end
                else          begin if3.ADDR = a2; if3.Data_from_CPU = d2; end
            end
        end
        if (sel == 1) begin if1.Mem_WE = 1'b0; if1.Mem_OE = 1'b0; end
        else          begin if3.Mem_WE = 1'b0; if3.Mem_OE = 1'b0; end
        step();
    endtask

    task automatic rd(input int sel, input logic [15:0] a, input int cyc,
                      output int lat, output logic [15:0] data, output logic vafter);
        logic v;
        lat  = -1;
        data = 16'h0000;
        if (sel == 1) begin if1.ADDR = a; if1.Mem_OE = 1'b1; end
        else          begin if3.ADDR = a; if3.Mem_OE = 1'b1; end
        for (int k = 1; k <= cyc; k++) begin
            step();
            v = (sel == 1) ? if1.Data_valid : if3.Data_valid;
            if (v === 1'b1 && lat < 0) begin
                lat  = k;
                data = (sel == 1) ? if1.Data_to_CPU : if3.Data_to_CPU;
            end
        end
        if (sel == 1) if1.Mem_OE = 1'b0;
        else          if3.Mem_OE = 1'b0;
        step();
        vafter = (sel == 1) ? if1.Data_valid : if3.Data_valid;
    endtask

    task automatic test_reset();
        if1.Mem_OE = 0; if1.Mem_WE = 0; if1.ADDR = 0; if1.Data_from_CPU = 0; if1.Switches = 0;
        if3.Mem_OE = 0; if3.Mem_WE = 0; if3.ADDR = 0; if3.Data_from_CPU = 0; if3.Switches = 0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        n_total++;
        if (if1.Data_valid !== 1'b0) $display("FAIL rst_valid1: got %b want 0", if1.Data_valid);
        else n_pass++;
        n_total++;
        if (if1.Data_to_CPU !== 16'h0) $display("FAIL rst_data1: got %h want 0000", if1.Data_to_CPU);
        else n_pass++;
        n_total++;
        if (if1.HEX_out !== 16'h0) $display("FAIL rst_hex1: got %h want 0000", if1.HEX_out);
        else n_pass++;
        n_total++;
        if (if1.Err !== 1'b0) $display("FAIL rst_err1: got %b want 0", if1.Err);
        else n_pass++;
        n_total++;
        if (if3.Data_valid !== 1'b0 || if3.Err !== 1'b0 || if3.HEX_out !== 16'h0)
            $display("FAIL rst_dut3: got v=%b e=%b hex=%h want 0/0/0000",
                     if3.Data_valid, if3.Err, if3.HEX_out);
        else n_pass++;
    endtask

    task automatic test_write_read();
        int lat; logic [15:0] d; logic va; logic [15:0] e;
        wr(1, 16'h0005, 16'h1234, 2, 1'b0, 16'h0005, 16'h1234);
        wr(3, 16'h0005, 16'h1234, 2, 1'b0, 16'h0005, 16'h1234);
        wr(1, 16'h03FF, 16'hA5A5, 1, 1'b0, 16'h03FF, 16'hA5A5);
        exp_q.push_back(m1[5]);
        rd(1, 16'h0005, 2, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (d !== e) $display("FAIL wr_rd_data: got %h want %h", d, e);
        else n_pass++;
        n_total++;
        if (lat != 1) $display("FAIL wr_rd_lat: got %0d want 1", lat);
        else n_pass++;
        n_total++;
        if (va !== 1'b0) $display("FAIL wr_rd_vdrop: got %b want 0", va);
        else n_pass++;
        exp_q.push_back(m1[16'h3FF]);
        rd(1, 16'h03FF, 3, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (d !== e || lat != 1) $display("FAIL top_word: got %h lat %0d want %h lat 1", d, lat, e);
        else n_pass++;
        n_total++;
        if (if1.Err !== 1'b0) $display("FAIL wr_rd_err: got %b want 0", if1.Err);
        else n_pass++;
    endtask

    task automatic test_io();
        int lat; logic [15:0] d; logic va; logic [15:0] e;
        wr(1, 16'hFFFF, 16'hBEEF, 1, 1'b0, 16'hFFFF, 16'hBEEF);
        n_total++;
        if (if1.HEX_out !== 16'hBEEF) $display("FAIL io_hex: got %h want beef", if1.HEX_out);
        else n_pass++;
        if1.Switches = 16'h00A5;
        step();
        exp_q.push_back(16'h00A5);
        rd(1, 16'hFFFF, 2, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (d !== e || lat != 1) $display("FAIL io_sw: got %h lat %0d want %h lat 1", d, lat, e);
        else n_pass++;
        n_total++;
        if (if1.Err !== 1'b0 || if1.HEX_out !== 16'hBEEF)
            $display("FAIL io_side: got err=%b hex=%h want 0/beef", if1.Err, if1.HEX_out);
        else n_pass++;
    endtask

    task automatic test_latency3();
        int lat; logic [15:0] d; logic va; logic [15:0] e;
        exp_q.push_back(m3[5]);
        rd(3, 16'h0005, 4, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (lat != 3) $display("FAIL lat3_edges: got %0d want 3", lat);
        else n_pass++;
        n_total++;
        if (d !== e) $display("FAIL lat3_data: got %h want %h", d, e);
        else n_pass++;
        n_total++;
        if (va !== 1'b0) $display("FAIL lat3_vdrop: got %b want 0", va);
        else n_pass++;
        rd(3, 16'h0005, 1, lat, d, va);
        n_total++;
        if (lat != -1 || va !== 1'b0) $display("FAIL lat3_abort: got lat %0d v %b want -1/0", lat, va);
        else n_pass++;
        exp_q.push_back(m3[5]);
        rd(3, 16'h0005, 4, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (lat != 3 || d !== e) $display("FAIL lat3_after_abort: got %h lat %0d want %h lat 3", d, lat, e);
        else n_pass++;
    endtask

    task automatic test_conflict();
        int lat; logic [15:0] d; logic va; logic [15:0] e;
        wr(1, 16'h0010, 16'h0F0F, 1, 1'b1, 16'h0010, 16'h0F0F);
        n_total++;
        if (if1.Data_valid !== 1'b0) $display("FAIL conf_valid: got %b want 0", if1.Data_valid);
        else n_pass++;
        n_total++;
        if (if1.Err !== 1'b1) $display("FAIL conf_err: got %b want 1", if1.Err);
        else n_pass++;
        exp_q.push_back(m1[16'h10]);
        rd(1, 16'h0010, 2, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (d !== e || lat != 1) $display("FAIL conf_word: got %h lat %0d want %h lat 1", d, lat, e);
        else n_pass++;
        n_total++;
        if (if1.Err !== 1'b1) $display("FAIL conf_sticky: got %b want 1", if1.Err);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        int lat; logic [15:0] d; logic va; logic [15:0] e;
        n_total++;
        if (if3.Err !== 1'b0) $display("FAIL oor_pre_err: got %b want 0", if3.Err);
        else n_pass++;
        exp_q.push_back(16'h0000);
        rd(3, 16'h2000, 4, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (d !== e || lat != 3) $display("FAIL oor_data: got %h lat %0d want %h lat 3", d, lat, e);
        else n_pass++;
        n_total++;
        if (if3.Err !== 1'b1) $display("FAIL oor_err: got %b want 1", if3.Err);
        else n_pass++;
        wr(1, 16'h0021, 16'h5555, 1, 1'b0, 16'h0021, 16'h5555);
        wr(1, 16'h0020, 16'h1111, 5, 1'b0, 16'h0021, 16'h2222);
        exp_q.push_back(m1[16'h20]);
        rd(1, 16'h0020, 2, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (d !== e) $display("FAIL single_commit_a: got %h want %h", d, e);
        else n_pass++;
        exp_q.push_back(m1[16'h21]);
        rd(1, 16'h0021, 2, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (d !== e) $display("FAIL single_commit_b: got %h want %h", d, e);
        else n_pass++;
    endtask

    task automatic test_reset_midread();
        int lat; logic [15:0] d; logic va; logic [15:0] e;
        wr(3, 16'hFFFF, 16'hBEEF, 1, 1'b0, 16'hFFFF, 16'hBEEF);
        n_total++;
        if (if3.HEX_out !== 16'hBEEF) $display("FAIL rm_hex_pre: got %h want beef", if3.HEX_out);
        else n_pass++;
        if3.ADDR = 16'h0005;
        if3.Mem_OE = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        if3.Mem_OE = 1'b0;
        n_total++;
        if (if3.Data_valid !== 1'b0 || if3.HEX_out !== 16'h0 || if3.Err !== 1'b0)
            $display("FAIL rm_clear: got v=%b hex=%h err=%b want 0/0000/0",
                     if3.Data_valid, if3.HEX_out, if3.Err);
        else n_pass++;
        n_total++;
        if (if1.HEX_out !== 16'h0 || if1.Err !== 1'b0)
            $display("FAIL rm_clear1: got hex=%h err=%b want 0000/0", if1.HEX_out, if1.Err);
        else n_pass++;
        exp_q.push_back(m3[5]);
        rd(3, 16'h0005, 4, lat, d, va);
        e = exp_q.pop_front();
        n_total++;
        if (d !== e || lat != 3) $display("FAIL rm_array: got %h lat %0d want %h lat 3", d, lat, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_io();
        test_latency3();
        test_conflict();
        test_out_of_range();
        test_reset_midread();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end
endmodule
